// File: rtl/prio_encoder_queue.sv
// Sequential N:log2(N) priority encoder: request events collect in a pending
// register and are handed out one index per transfer, highest index first.
module prio_encoder_queue #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         e,
    input  logic [N-1:0] req,
    output logic [W-1:0] y,
    output logic         y_valid,
    input  logic         y_ready,
    output logic [N-1:0] pending,
    output logic         dup_err
);

    // Handshake: y/y_valid form a valid/ready source. A transfer happens on an
    // edge where y_valid && y_ready; while y_valid && !y_ready, y and y_valid
    // hold. The output register can refill on the same edge it is drained.

    logic [N-1:0] cand;
    logic [N-1:0] cand_clr;
    logic [W-1:0] k;
    logic         slot_free;
    logic         load;

    always_comb begin
        cand      = pending | (e ? req : '0);
        slot_free = !y_valid || y_ready;
        load      = e && slot_free && (cand != '0);
    end

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                k = W'(i);
            end
        end
        cand_clr    = cand;
        cand_clr[k] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            y_valid <= 1'b0;
            pending <= '0;
            dup_err <= 1'b0;
        end else begin
            if (load) begin
                y       <= k;
                y_valid <= 1'b1;
                pending <= cand_clr;
            end else begin
                if (e) begin
                    pending <= cand;
                end
                if (y_valid && y_ready) begin
                    y_valid <= 1'b0;
                end
            end
            // A request landing on an already-pending line merges into it.
            if (e && ((req & pending) != '0)) begin
                dup_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_queue.sv
// Bench for prio_encoder_queue: directed scenarios followed by random traffic,
// every cycle compared against a set-based reference model.
module tb_prio_encoder_queue;

    localparam int N = 4;
    localparam int W = $clog2(N);

    logic         clk;
    logic         rst_n;
    logic         e;
    logic [N-1:0] req;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;
    logic [N-1:0] pending;
    logic         dup_err;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_one = 0;

    // reference model state: set of pending lines plus one output slot
    bit pend_m[N];
    bit vld_m;
    int y_m;
    bit dup_m;

    prio_encoder_queue #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .e       (e),
        .req     (req),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .pending (pending),
        .dup_err (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pend_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = pend_m[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) pend_m[i] = 1'b0;
        vld_m = 1'b0;
        y_m   = 0;
        dup_m = 1'b0;
    endfunction

    function automatic void model_edge(input bit e_i, input bit [N-1:0] req_i, input bit rdy_i);
        bit cand[N];
        int top = -1;
        for (int i = 0; i < N; i++) begin
            cand[i] = pend_m[i] || (e_i && req_i[i]);
            if (e_i && req_i[i] && pend_m[i]) dup_m = 1'b1;
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                top = i;
                break;
            end
        end
        if (e_i && (!vld_m || rdy_i) && top >= 0) begin
            y_m       = top;
            vld_m     = 1'b1;
            cand[top] = 1'b0;
        end else if (vld_m && rdy_i) begin
            vld_m = 1'b0;
        end
        if (e_i) begin
            for (int i = 0; i < N; i++) pend_m[i] = cand[i];
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".y_valid"}, 32'(y_valid), 32'(vld_m));
        check({tag, ".y"},       32'(y),       32'(y_m));
        check({tag, ".pending"}, 32'(pending), pend_vec());
        check({tag, ".dup_err"}, 32'(dup_err), 32'(dup_m));
    endtask

    // Drive at negedge, clock it in, update the model, compare after the edge.
    task automatic step(input string tag, input bit e_i, input logic [N-1:0] req_i, input bit rdy_i);
        @(negedge clk);
        rst_n   = 1'b1;
        e       = e_i;
        req     = req_i;
        y_ready = rdy_i;
        #1;
        if (y_valid && y_ready && y == W'(1)) xfer_one++;
        @(posedge clk);
        model_edge(e_i, req_i, rdy_i);
        #1;
        check_all(tag);
    endtask

    // Asserts reset between clock edges and checks the immediate clear.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".y_valid"}, 32'(y_valid), 32'd0);
        check({tag, ".y"},       32'(y),       32'd0);
        check({tag, ".pending"}, 32'(pending), 32'd0);
        check({tag, ".dup_err"}, 32'(dup_err), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        e       = 1'b0;
        req     = '0;
        y_ready = 1'b0;
        model_reset();
        #12;
        check_all("por");

        // Reset mid-stall with y_valid high and pending = 0101
        step("rst_setup0", 1, 4'b1000, 0);
        step("rst_setup1", 1, 4'b0101, 0);
        check("rst_pre.pending", 32'(pending), 32'h5);
        check("rst_pre.y", 32'(y), 32'd3);
        async_reset("rst_async");

        // Serialisation of a multi-hot request
        step("ser0", 1, 4'b0110, 1);
        check("ser0.y_is_2", 32'(y), 32'd2);
        step("ser1", 1, 4'b0000, 1);
        check("ser1.y_is_1", 32'(y), 32'd1);
        step("ser2", 1, 4'b0000, 1);
        check("ser2.idle", 32'({y_valid, pending}), 32'h0);

        // Backpressure with a request arriving during the stall
        step("bp0", 1, 4'b1000, 0);
        step("bp1", 1, 4'b0001, 0);
        step("bp2", 1, 4'b0000, 0);
        check("bp2.held_y", 32'({y_valid, y}), 32'h7);
        check("bp2.pending", 32'(pending), 32'h1);
        step("bp3", 1, 4'b0000, 1);
        check("bp3.y_is_0", 32'({y_valid, y}), 32'h4);
        step("bp4", 1, 4'b0000, 1);
        check("bp4.drained", 32'(y_valid), 32'd0);

        // Enable gating: requests ignored while e = 0, pending resumes later
        step("en0", 0, 4'b1111, 1);
        step("en1", 0, 4'b1111, 1);
        check("en1.ignored", 32'({y_valid, pending}), 32'h0);
        step("en2", 1, 4'b1000, 0);
        step("en3", 1, 4'b0100, 0);
        step("en4", 0, 4'b0000, 1);
        check("en4.pending_kept", 32'({y_valid, pending}), 32'h4);
        step("en5", 1, 4'b0000, 1);
        check("en5.y_is_2", 32'({y_valid, y}), 32'h6);
        step("en6", 1, 4'b0000, 1);

        // Duplicate request on a pending line merges and sets the sticky flag
        step("dup0", 1, 4'b1000, 0);
        step("dup1", 1, 4'b0010, 0);
        step("dup2", 1, 4'b0000, 0);
        step("dup3", 1, 4'b0010, 0);
        check("dup3.flag", 32'({dup_err, pending}), 32'h12);
        xfer_one = 0;
        step("dup4", 1, 4'b0000, 1);
        step("dup5", 1, 4'b0000, 1);
        step("dup6", 1, 4'b0000, 1);
        check("dup.single_xfer", 32'(xfer_one), 32'd1);
        check("dup.sticky", 32'(dup_err), 32'd1);
        async_reset("rst_after_dup");

        // Full load: all lines at once drain 3,2,1,0 on consecutive edges
        step("full0", 1, 4'b1111, 1);
        check("full0.y", 32'(y), 32'd3);
        step("full1", 1, 4'b0000, 1);
        check("full1.y", 32'(y), 32'd2);
        step("full2", 1, 4'b0000, 1);
        check("full2.y", 32'(y), 32'd1);
        step("full3", 1, 4'b0000, 1);
        check("full3.y", 32'(y), 32'd0);
        step("full4", 1, 4'b0000, 1);
        check("full4.idle", 32'(y_valid), 32'd0);

        // Random traffic against the model, with an occasional reset
        for (int n = 0; n < 400; n++) begin
            bit           e_r;
            bit           rdy_r;
            logic [N-1:0] req_r;
            e_r   = ($urandom_range(0, 7) != 0);
            rdy_r = ($urandom_range(0, 2) != 0);
            req_r = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            if (n % 137 == 136) async_reset("rnd_rst");
            step("rnd", e_r, req_r, rdy_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
